hazard_fwd_unit: RTL and testbench
==================================

HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 The block SHALL have parameters: AW, default 5, register-address width; MD_LAT, default 4, multi-cycle (mul/div) latency in cycles, legal range 2..15; CW, default 16, stall-counter width.
REQ-002 Ports SHALL be one per line, as listed in REQ-003 to REQ-016 (clock and reset first).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 id_rs, id_rt  in  AW each  source registers of the ID-stage instruction.
REQ-006 id_use_rs, id_use_rt  in  1 each  ID instruction actually reads rs / rt.
REQ-007 id_md_start  in  1  ID instruction is a multi-cycle op.
REQ-008 id_md_dst  in  AW  destination register of that multi-cycle op.
REQ-009 ex_regwr, mem_regwr, wb_regwr  in  1 each  stage writes a register.
REQ-010 ex_reg, mem_reg, wb_reg  in  AW each  stage destination register.
REQ-011 ex_memrd  in  1  EX-stage instruction is a load.
REQ-012 flush_id  in  1  ID instruction is being cancelled (taken branch).
REQ-013 fwd_a, fwd_b  out  2 each  operand source select: 00 register file, 01 EX, 10 MEM, 11 WB.
REQ-014 stall  out  1  hold PC and IF/ID.
REQ-015 bubble  out  1  load zero-control into ID/EX.
REQ-016 md_busy  out  1; md_done  out  1; stall_cnt  out  CW.

Function
REQ-017 Forwarding SHALL be combinational: for fwd_a, the nearest stage X in EX>MEM>WB priority with X_regwr=1, X_reg!=0, X_reg==id_rs; else 00. fwd_b SHALL be identical using id_rt.
REQ-018 Register 0 SHALL never produce forwarding, load-use or scoreboard hazards.
REQ-019 A load-use hazard (lu) SHALL be ex_memrd & ex_regwr & ex_reg!=0 & ((id_use_rs & ex_reg==id_rs) | (id_use_rt & ex_reg==id_rt)).
REQ-020 The multi-cycle FSM SHALL have states IDLE and BUSY with a down-counter cnt of width ceil(log2(MD_LAT)).
REQ-021 IDLE->BUSY SHALL occur when id_md_start=1, stall=0 and flush_id=0; the FSM then loads cnt=MD_LAT-1 and latches md_dst=id_md_dst.
REQ-022 In BUSY, cnt SHALL decrement each cycle; when cnt==0, the FSM SHALL return to IDLE and md_done SHALL pulse high for exactly that cycle.
REQ-023 md_busy SHALL be 1 exactly while the state is BUSY, so a start at edge N gives md_busy high for MD_LAT cycles.
REQ-024 A scoreboard hazard (sb) SHALL be md_busy & ((id_use_rs & id_rs==md_dst) | (id_use_rt & id_rt==md_dst) | id_md_start), excluding the md_done cycle, where the result is deemed available via WB.
REQ-025 The outputs SHALL be stall = (lu | sb) & ~flush_id and bubble = stall; flush_id SHALL override all hazards.
REQ-026 A stalled id_md_start SHALL not start the FSM; it starts on the first non-stalled cycle.
REQ-027 stall_cnt SHALL increment on every cycle with stall=1 and saturate at 2^CW-1 (no wrap).
REQ-028 Forwarding selects SHALL remain valid during stall cycles (they are not gated).

Reset
REQ-029 With rst_n=0, asynchronously: state=IDLE, cnt=0, md_dst=0, stall_cnt=0, md_busy=0, md_done=0.
REQ-030 Reset asserted mid-BUSY SHALL abort the operation with no md_done pulse; after release, stall and bubble SHALL depend only on lu.
REQ-031 On the first edge after rst_n rises, the FSM SHALL accept id_md_start normally.

Verification
REQ-032 ex_regwr=1, ex_reg=8, mem_regwr=1, mem_reg=8, id_rs=8 -> fwd_a=01; with ex_regwr=0 -> fwd_a=10; with id_rs=0 and all stages reg 0 -> fwd_a=00.
REQ-033 ex_memrd=1, ex_reg=5, id_rt=5, id_use_rt=1 -> stall=bubble=1 for one cycle and stall_cnt +1; same stimulus with flush_id=1 -> stall=0.
REQ-034 MD_LAT=4, id_md_start with dst=9 at edge 0 -> md_busy high for cycles 1-4, md_done high in cycle 4 only; an id_rs=9 reader stalls in cycles 1-3 and not in cycle 4.
REQ-035 A second id_md_start while BUSY -> stall held until the md_done cycle, then the FSM restarts on that edge (md_busy is continuous).
REQ-036 CW=4 with a continuous hazard for 20 cycles -> stall_cnt saturates at 15.
REQ-037 rst_n pulsed low at the 2nd BUSY cycle -> md_busy=0 immediately, no md_done pulse, stall_cnt=0.

Source files
------------

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: operand forwarding, load-use and multi-cycle scoreboard stall control
module hazard_fwd_unit #(
  parameter int AW     = 5,
  parameter int MD_LAT = 4,
  parameter int CW     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic          id_md_start,
  input  logic [AW-1:0] id_md_dst,
  input  logic          ex_regwr,
  input  logic          mem_regwr,
  input  logic          wb_regwr,
  input  logic [AW-1:0] ex_reg,
  input  logic [AW-1:0] mem_reg,
  input  logic [AW-1:0] wb_reg,
  input  logic          ex_memrd,
  input  logic          flush_id,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          stall,
  output logic          bubble,
  output logic          md_busy,
  output logic          md_done,
  output logic [CW-1:0] stall_cnt
);
  localparam int NW = $clog2(MD_LAT);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nx;
  logic [NW-1:0] cnt, cnt_nx;
  logic [AW-1:0] md_dst, md_dst_nx;
  logic ex_ok, mem_ok, wb_ok, lu, sb, start;
  assign ex_ok  = ex_regwr & |ex_reg;
  assign mem_ok = mem_regwr & |mem_reg;
  assign wb_ok  = wb_regwr & |wb_reg;
  assign fwd_a = (ex_ok && ex_reg == id_rs) ? 2'b01 :
                 (mem_ok && mem_reg == id_rs) ? 2'b10 :
                 (wb_ok && wb_reg == id_rs) ? 2'b11 : 2'b00;
  assign fwd_b = (ex_ok && ex_reg == id_rt) ? 2'b01 :
                 (mem_ok && mem_reg == id_rt) ? 2'b10 :
                 (wb_ok && wb_reg == id_rt) ? 2'b11 : 2'b00;
  assign lu = ex_memrd & ex_ok & ((id_use_rs & (ex_reg == id_rs)) | (id_use_rt & (ex_reg == id_rt)));
  assign md_busy = state == BUSY;
  assign md_done = md_busy & (cnt == '0);
  // on the done cycle the result is taken from WB, so readers proceed
  assign sb = md_busy & ~md_done & ((id_use_rs & |md_dst & (id_rs == md_dst)) |
                                    (id_use_rt & |md_dst & (id_rt == md_dst)) | id_md_start);
  assign stall  = (lu | sb) & ~flush_id;
  assign bubble = stall;
  assign start  = id_md_start & ~stall & ~flush_id & (~md_busy | md_done);
  always_comb begin
    state_nx  = start ? BUSY : md_done ? IDLE : state;
    cnt_nx    = start ? NW'(MD_LAT - 1) : (md_busy & ~md_done) ? cnt - NW'(1) : cnt;
    md_dst_nx = start ? id_md_dst : md_dst;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      md_dst    <= '0;
      stall_cnt <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      md_dst <= md_dst_nx;
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: directed scoreboard bench for hazard_fwd_unit (MD_LAT=4, CW=4)
module tb_hazard_fwd_unit;
  logic clk = 0, rst_n;
  logic [4:0] id_rs, id_rt, id_md_dst, ex_reg, mem_reg, wb_reg;
  logic id_use_rs, id_use_rt, id_md_start, ex_regwr, mem_regwr, wb_regwr, ex_memrd, flush_id;
  logic [1:0] fwd_a, fwd_b;
  logic stall, bubble, md_busy, md_done;
  logic [3:0] stall_cnt;
  int checks = 0, errors = 0;
  logic [3:0] ecnt = 0;
  typedef struct {
    logic [1:0] a, b;
    logic s, busy, done;
    logic [3:0] cnt;
  } exp_t;
  exp_t q[$];

  hazard_fwd_unit #(.AW(5), .MD_LAT(4), .CW(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_md_start(id_md_start), .id_md_dst(id_md_dst),
    .ex_regwr(ex_regwr), .mem_regwr(mem_regwr), .wb_regwr(wb_regwr), .ex_reg(ex_reg),
    .mem_reg(mem_reg), .wb_reg(wb_reg), .ex_memrd(ex_memrd), .flush_id(flush_id),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .bubble(bubble), .md_busy(md_busy),
    .md_done(md_done), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    {id_rs, id_rt, id_md_dst, ex_reg, mem_reg, wb_reg} = '0;
    {id_use_rs, id_use_rt, id_md_start, ex_regwr, mem_regwr, wb_regwr, ex_memrd, flush_id} = '0;
  endtask

  // push expectation, sample mid-cycle, pop and compare, advance to next negedge
  task automatic chk(input string tag, input logic [1:0] a, input logic [1:0] b,
                     input logic s, input logic busy, input logic done);
    exp_t e;
    q.push_back('{a, b, s, busy, done, ecnt});
    #2;
    e = q.pop_front();
    cmp({tag, ".fwd_a"}, 32'(fwd_a), 32'(e.a));
    cmp({tag, ".fwd_b"}, 32'(fwd_b), 32'(e.b));
    cmp({tag, ".stall"}, 32'(stall), 32'(e.s));
    cmp({tag, ".bubble"}, 32'(bubble), 32'(e.s));
    cmp({tag, ".md_busy"}, 32'(md_busy), 32'(e.busy));
    cmp({tag, ".md_done"}, 32'(md_done), 32'(e.done));
    cmp({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(e.cnt));
    if (e.s && rst_n) ecnt = (ecnt == 4'd15) ? 4'd15 : ecnt + 4'd1;
    @(negedge clk);
  endtask

  initial begin
    clr(); rst_n = 0;
    #2 chk("reset", 0, 0, 0, 0, 0);
    rst_n = 1;
    ex_regwr = 1; ex_reg = 8; mem_regwr = 1; mem_reg = 8; id_rs = 8;
    chk("fwd_ex", 2'b01, 0, 0, 0, 0);
    ex_regwr = 0;
    chk("fwd_mem", 2'b10, 0, 0, 0, 0);
    mem_regwr = 0; wb_regwr = 1; wb_reg = 3; id_rt = 3;
    chk("fwd_wb", 0, 2'b11, 0, 0, 0);
    clr(); ex_regwr = 1; mem_regwr = 1; wb_regwr = 1;
    chk("fwd_r0", 0, 0, 0, 0, 0);
    clr(); ex_memrd = 1; ex_regwr = 1; ex_reg = 5; id_rt = 5; id_use_rt = 1;
    chk("lu", 0, 2'b01, 1, 0, 0);
    flush_id = 1;
    chk("lu_flush", 0, 2'b01, 0, 0, 0);
    flush_id = 0; ex_reg = 0; id_rt = 0;
    chk("lu_r0", 0, 0, 0, 0, 0);
    clr(); id_md_start = 1; id_md_dst = 9;
    chk("md_start", 0, 0, 0, 0, 0);
    clr(); id_rs = 9; id_use_rs = 1;
    for (int i = 1; i <= 3; i++) chk($sformatf("md_rd%0d", i), 0, 0, 1, 1, 0);
    chk("md_rd_done", 0, 0, 0, 1, 1);
    chk("md_idle", 0, 0, 0, 0, 0);
    clr(); id_md_start = 1; id_md_dst = 9;
    chk("md2_start", 0, 0, 0, 0, 0);
    id_md_dst = 10;
    for (int i = 1; i <= 3; i++) chk($sformatf("md2_hold%0d", i), 0, 0, 1, 1, 0);
    chk("md2_restart", 0, 0, 0, 1, 1);
    clr(); id_rs = 10; id_use_rs = 1;
    for (int i = 1; i <= 3; i++) chk($sformatf("md2_rd%0d", i), 0, 0, 1, 1, 0);
    chk("md2_done", 0, 0, 0, 1, 1);
    clr(); id_md_start = 1;
    chk("md0_start", 0, 0, 0, 0, 0);
    clr(); id_use_rs = 1;
    chk("md0_rd", 0, 0, 0, 1, 0);
    clr();
    chk("md0_b2", 0, 0, 0, 1, 0);
    chk("md0_b3", 0, 0, 0, 1, 0);
    chk("md0_done", 0, 0, 0, 1, 1);
    id_md_start = 1; flush_id = 1; id_md_dst = 9;
    chk("md_flush", 0, 0, 0, 0, 0);
    flush_id = 0; ex_memrd = 1; ex_regwr = 1; ex_reg = 6; id_rs = 6; id_use_rs = 1;
    chk("md_stalled", 2'b01, 0, 1, 0, 0);
    clr();
    chk("md_nostart", 0, 0, 0, 0, 0);
    id_md_start = 1; id_md_dst = 9;
    chk("rst_start", 0, 0, 0, 0, 0);
    clr(); id_rs = 9; id_use_rs = 1;
    chk("rst_b1", 0, 0, 1, 1, 0);
    rst_n = 0; ecnt = 0;
    chk("rst_abort", 0, 0, 0, 0, 0);
    rst_n = 1;
    chk("rst_after", 0, 0, 0, 0, 0);
    clr(); id_md_start = 1; id_md_dst = 9;
    chk("rst_restart", 0, 0, 0, 0, 0);
    clr();
    chk("rst_busy1", 0, 0, 0, 1, 0);
    chk("rst_busy2", 0, 0, 0, 1, 0);
    chk("rst_busy3", 0, 0, 0, 1, 0);
    chk("rst_done", 0, 0, 0, 1, 1);
    ex_memrd = 1; ex_regwr = 1; ex_reg = 5; id_rt = 5; id_use_rt = 1;
    for (int i = 0; i < 20; i++) chk($sformatf("sat%0d", i), 0, 2'b01, 1, 0, 0);
    clr();
    chk("sat_hold", 0, 0, 0, 0, 0);
    cmp("queue_empty", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
